// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin grant, snoop broadcast and completion sequencing for a shared MSI bus
module snoop_bus_arbiter #(
  parameter int NUM_CPUS    = 2,
  parameter int NUM_LINES   = 2,
  parameter int MEM_LATENCY = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_CPUS-1:0]           req_i,
  input  logic [3*NUM_CPUS-1:0]         msg_i,
  input  logic [NUM_LINES*NUM_CPUS-1:0] addr_i,
  input  logic [NUM_CPUS-1:0]           flush_i,
  output logic [NUM_CPUS-1:0]           gnt_o,
  output logic [2:0]                    bus_msg_o,
  output logic [NUM_LINES-1:0]          bus_addr_o,
  output logic [$clog2(NUM_CPUS)-1:0]   bus_owner_o,
  output logic                          busy_o,
  output logic                          data_valid_o,
  output logic                          multi_flush_err_o
);
  localparam int OW = $clog2(NUM_CPUS);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [OW:0]   NC   = (OW+1)'(NUM_CPUS);
  localparam logic [OW-1:0] LAST = OW'(NUM_CPUS - 1);
  localparam logic [2:0]    UPGR = 3'd3;
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_BCAST, S_MEM, S_DONE} state_t;
  state_t                r_state;
  logic [OW-1:0]         r_rr, r_owner;
  logic [CW-1:0]         r_cnt;
  logic [NUM_CPUS-1:0]   r_gnt;
  logic [2:0]            r_bus_msg;
  logic [NUM_LINES-1:0]  r_bus_addr;
  logic                  r_busy, r_dv, r_err;
  logic [2*NUM_CPUS-1:0] w_dbl;
  logic [NUM_CPUS-1:0]   w_rot, w_fl;
  logic [OW-1:0]         w_off, w_win, w_nxt;
  logic [OW:0]           w_sum;
  logic [2:0]            w_msg;
  logic [NUM_LINES-1:0]  w_addr;
  logic                  w_found, w_bad, w_upgr, w_multi;
  // rotate requests so bit 0 is the rr_ptr position; lowest set bit then wins
  assign w_dbl   = {req_i, req_i} >> r_rr;
  assign w_rot   = w_dbl[NUM_CPUS-1:0];
  assign w_found = |w_rot;
  always_comb begin
    w_off = '0;
    for (int i = NUM_CPUS - 1; i >= 0; i--)
      if (w_rot[i]) w_off = OW'(i);
  end
  assign w_sum = {1'b0, r_rr} + {1'b0, w_off};
  assign w_win = (w_sum >= NC) ? OW'(w_sum - NC) : OW'(w_sum);
  assign w_nxt = (w_win == LAST) ? '0 : w_win + 1'b1;
  always_comb begin
    w_msg  = '0;
    w_addr = '0;
    w_fl   = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (r_owner == OW'(i)) begin
        w_msg  = msg_i[3*i +: 3];
        w_addr = addr_i[NUM_LINES*i +: NUM_LINES];
      end
      w_fl[i] = flush_i[i] & (r_owner != OW'(i));
    end
  end
  assign w_bad   = (w_msg == 3'd0) || w_msg[2];
  assign w_upgr  = (r_bus_msg == UPGR);
  assign w_multi = ($countones(w_fl) > 1);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_rr       <= '0;
      r_owner    <= '0;
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_bus_msg  <= '0;
      r_bus_addr <= '0;
      r_busy     <= 1'b0;
      r_dv       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_gnt      <= '0;
      r_bus_msg  <= '0;
      r_bus_addr <= '0;
      r_dv       <= 1'b0;
      case (r_state)
        S_IDLE: if (w_found) begin
          r_state <= S_GRANT;
          r_gnt   <= NUM_CPUS'(1) << w_win;
          r_owner <= w_win;
          r_rr    <= w_nxt;
          r_busy  <= 1'b1;
        end
        S_GRANT: if (w_bad) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end else begin
          r_state    <= S_BCAST;
          r_bus_msg  <= w_msg;
          r_bus_addr <= w_addr;
        end
        S_BCAST: if (w_upgr || (|w_fl)) begin
          r_state <= S_DONE;
          r_dv    <= 1'b1;
          if (!w_upgr && w_multi) r_err <= 1'b1;
        end else begin
          r_state <= S_MEM;
          r_cnt   <= CW'(MEM_LATENCY - 1);
        end
        S_MEM: if (r_cnt == '0) begin
          r_state <= S_DONE;
          r_dv    <= 1'b1;
        end else r_cnt <= r_cnt - 1'b1;
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  assign gnt_o             = r_gnt;
  assign bus_msg_o         = r_bus_msg;
  assign bus_addr_o        = r_bus_addr;
  assign bus_owner_o       = r_owner;
  assign busy_o            = r_busy;
  assign data_valid_o      = r_dv;
  assign multi_flush_err_o = r_err;
endmodule
